serial_receiver: RTL and testbench

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver_pkg.sv | 16 +
 rtl/serial_receiver_sync_2ff.sv | 23 ++
 rtl/serial_receiver.sv | 103 ++++++++++
 tb/tb_serial_receiver.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial receiver: FSM encoding and line-level constants.
package serial_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_receiver_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line.
module sync_2ff
  import serial_receiver_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Serial byte receiver: start 1, 8 data bits MSB first, stop 0, mid-bit sampling.
// state | meaning: IDLE wait for 0->1 edge | START confirm start bit | DATA shift 8 bits | STOP check stop bit
module serial_receiver
  import serial_receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam int              IW        = $clog2(DATA_BITS);
  localparam logic [CW-1:0]   HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

  rx_state_e                state;
  rx_state_e                state_next;
  logic                     rxd_s;
  logic                     rxd_prev;
  logic [1:0]               warm;
  logic [CW-1:0]            bit_cnt;
  logic [IW-1:0]            bit_idx;
  logic [DATA_BITS-1:0]     shift;
  logic                     tick;
  logic                     start_edge;
  logic                     sample_bit;
  logic                     accept;
  logic                     reject;
  logic                     load_cnt;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  // The previous-sample flop holds the start level until the synchronizer has
  // refilled after reset, so a line already high at release cannot look like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      warm     <= 2'b00;
      rxd_prev <= START_BIT;
    end else begin
      warm     <= {warm[0], 1'b1};
      rxd_prev <= warm[1] ? rxd_s : START_BIT;
    end
  end

  assign start_edge = (rxd_s == START_BIT) && (rxd_prev == IDLE_LEVEL);
  assign tick       = (bit_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_edge) state_next = START;
      START:   if (tick) state_next = (rxd_s == START_BIT) ? DATA : IDLE;
      DATA:    if (tick && (bit_idx == IW'(DATA_BITS - 1))) state_next = STOP;
      STOP:    if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    sample_bit = (state == DATA) && tick;
    accept     = (state == STOP) && tick && (rxd_s == STOP_BIT);
    reject     = (state == STOP) && tick && (rxd_s != STOP_BIT);
    load_cnt   = (state_next != state) || sample_bit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= accept;
      frame_err <= reject;
      if (load_cnt)  bit_cnt <= (state_next == START) ? HALF_LOAD : BIT_LOAD;
      else if (!tick) bit_cnt <= bit_cnt - CW'(1);
      if (state == IDLE)   bit_idx <= '0;
      else if (sample_bit) bit_idx <= bit_idx + IW'(1);
      if (sample_bit) shift <= {shift[DATA_BITS-2:0], rxd_s};
      if (accept)     data  <= shift;
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Self-checking bench for serial_receiver: table vectors, corner sequences, random frames vs model.
module tb_serial_receiver;

  localparam int N    = 4;
  localparam int H    = N / 2;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  serial_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         gap;
    logic [7:0] payload;
    bit         stop_lvl;
    bit         exp_valid;
    bit         exp_err;
    logic [7:0] exp_data;
  } frame_vec_t;

  int checks = 0;
  int errors = 0;

  bit         line[$];
  logic [7:0] obs_data[MAXC];
  logic       obs_valid[MAXC];
  logic       obs_err[MAXC];
  logic       obs_busy[MAXC];
  logic [7:0] exp_data[MAXC];
  bit         exp_valid[MAXC];
  bit         exp_err[MAXC];
  bit         exp_busy[MAXC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add_bits(input bit v, input int n);
    repeat (n) line.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input bit stop_lvl);
    add_bits(1'b1, N);
    for (int k = 7; k >= 0; k--) add_bits(d[k], N);
    add_bits(stop_lvl, N);
  endtask

  // Synchronized line as seen in cycle c: one cycle behind the driven value.
  function automatic bit s_at(input int c);
    if (c >= 1 && (c - 1) < line.size()) return line[c-1];
    return 1'b0;
  endfunction

  task automatic mark_busy(input int a, input int b, input int len);
    for (int x = a; x <= b && x < len; x++) exp_busy[x] = 1'b1;
  endtask

  // Reference: scan the line for frames using the bit-timing arithmetic directly.
  task automatic build_model(input int len);
    int         c;
    int         t0;
    int         stop_c;
    logic [7:0] b;
    for (int x = 0; x < len; x++) begin
      exp_valid[x] = 1'b0;
      exp_err[x]   = 1'b0;
      exp_busy[x]  = 1'b0;
      exp_data[x]  = 8'h00;
    end
    c = 2;
    while (c < len) begin
      if (!(s_at(c) && !s_at(c - 1))) begin
        c++;
        continue;
      end
      t0 = c;
      if (!s_at(t0 + H)) begin
        mark_busy(t0 + 1, t0 + H, len);
        c = t0 + H + 1;
        continue;
      end
      stop_c = t0 + H + 9 * N;
      mark_busy(t0 + 1, stop_c, len);
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], s_at(t0 + H + (k + 1) * N)};
      if (stop_c + 1 < len) begin
        if (!s_at(stop_c)) begin
          exp_valid[stop_c+1] = 1'b1;
          for (int x = stop_c + 1; x < len; x++) exp_data[x] = b;
        end else begin
          exp_err[stop_c+1] = 1'b1;
        end
      end
      c = stop_c + 1;
    end
  endtask

  // Reset, release, drive line[] one value per cycle, then compare every cycle to the model.
  task automatic play(input string nm);
    int len;
    len = line.size();
    if (len > MAXC) len = MAXC;
    rst = 1'b0;
    rxd = line[0];
    repeat (3) @(negedge clk);
    chk({nm, ".rst_data"},  data,      8'h00);
    chk({nm, ".rst_valid"}, valid,     1'b0);
    chk({nm, ".rst_err"},   frame_err, 1'b0);
    chk({nm, ".rst_busy"},  busy,      1'b0);
    rst = 1'b1;
    for (int c = 0; c < len; c++) begin
      rxd = line[c];
      @(negedge clk);
      obs_valid[c] = valid;
      obs_err[c]   = frame_err;
      obs_busy[c]  = busy;
      obs_data[c]  = data;
    end
    build_model(len);
    for (int c = 0; c < len; c++) begin
      chk($sformatf("%s.valid@%0d", nm, c), obs_valid[c], exp_valid[c]);
      chk($sformatf("%s.err@%0d",   nm, c), obs_err[c],   exp_err[c]);
      chk($sformatf("%s.busy@%0d",  nm, c), obs_busy[c],  exp_busy[c]);
      chk($sformatf("%s.data@%0d",  nm, c), obs_data[c],  exp_data[c]);
    end
  endtask

  function automatic int count_events(input int a, input int b);
    int n;
    n = 0;
    for (int x = a; x <= b; x++) n += int'(obs_valid[x]) + int'(obs_err[x]);
    return n;
  endfunction

  initial begin
    frame_vec_t tv[5];
    int         rise[5];
    int         vq[$];
    int         e;
    int         r;
    int         act;

    tv[0] = '{5, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5};
    tv[1] = '{3, 8'h3C, 1'b1, 1'b0, 1'b1, 8'hA5};
    tv[2] = '{4, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[3] = '{0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF};
    tv[4] = '{2, 8'h81, 1'b1, 1'b0, 1'b1, 8'hFF};

    // Table frames, including good/bad stop and a back-to-back pair.
    line.delete();
    for (int i = 0; i < 5; i++) begin
      add_bits(1'b0, tv[i].gap);
      rise[i] = line.size();
      add_frame(tv[i].payload, tv[i].stop_lvl);
    end
    add_bits(1'b0, 10);
    play("table");
    for (int i = 0; i < 5; i++) begin
      e = rise[i] + 40;
      chk($sformatf("tbl%0d.valid", i), obs_valid[e], tv[i].exp_valid);
      chk($sformatf("tbl%0d.err", i),   obs_err[e],   tv[i].exp_err);
      chk($sformatf("tbl%0d.data", i),  obs_data[e],  tv[i].exp_data);
      chk($sformatf("tbl%0d.early", i), obs_valid[e-1] | obs_err[e-1], 1'b0);
    end
    vq.delete();
    for (int x = 0; x < line.size(); x++) if (obs_valid[x] === 1'b1) vq.push_back(x);
    chk("tbl.valid_count", vq.size(), 3);
    if (vq.size() >= 3) chk("tbl.b2b_spacing", vq[2] - vq[1], 40);

    // One-cycle glitch on an idle line.
    line.delete();
    add_bits(1'b0, 6);
    add_bits(1'b1, 1);
    add_bits(1'b0, 14);
    play("glitch");
    chk("glitch.busy_rose", obs_busy[8], 1'b1);
    chk("glitch.busy_fell", obs_busy[11], 1'b0);
    chk("glitch.no_event", count_events(0, line.size() - 1), 0);

    // Reset during data bit 3 of 0x5A, after a good 0xC3 frame.
    line.delete();
    add_bits(1'b0, 4);
    add_frame(8'hC3, 1'b0);
    add_bits(1'b0, 3);
    add_bits(1'b1, N);
    add_bits(1'b0, N);
    add_bits(1'b1, N);
    add_bits(1'b0, N);
    add_bits(1'b1, N);
    add_bits(1'b1, 2);
    play("rst_pre");
    chk("rst_pre.busy", busy, 1'b1);
    chk("rst_pre.data", data, 8'hC3);
    rst = 1'b0;
    #1;
    chk("rst_now.data",  data,      8'h00);
    chk("rst_now.valid", valid,     1'b0);
    chk("rst_now.err",   frame_err, 1'b0);
    chk("rst_now.busy",  busy,      1'b0);
    line.delete();
    add_bits(1'b1, 5);
    add_bits(1'b0, 4);
    r = line.size();
    add_frame(8'h3C, 1'b0);
    add_bits(1'b0, 8);
    play("rst_post");
    chk("rst_post.valid", obs_valid[r+40], 1'b1);
    chk("rst_post.data",  obs_data[r+40],  8'h3C);
    act = 0;
    for (int x = 0; x < line.size(); x++) act += int'(obs_valid[x]);
    chk("rst_post.valid_count", act, 1);

    // Bad stop then line held high: no retrigger until a fresh 0->1 edge.
    line.delete();
    add_bits(1'b0, 4);
    add_frame(8'h3C, 1'b1);
    add_bits(1'b1, 100);
    add_bits(1'b0, 4);
    add_bits(1'b1, 8);
    add_bits(1'b0, 4);
    play("stuck");
    chk("stuck.err",   obs_err[44],   1'b1);
    chk("stuck.valid", obs_valid[44], 1'b0);
    act = 0;
    for (int x = 45; x <= 149; x++) act += int'(obs_busy[x]) + int'(obs_valid[x]) + int'(obs_err[x]);
    chk("stuck.quiet", act, 0);
    chk("stuck.restart_busy", obs_busy[151], 1'b1);

    // Random frames, stop bits, gaps and short glitches.
    for (int seg = 0; seg < 3; seg++) begin
      line.delete();
      add_bits(1'b0, 3);
      for (int f = 0; f < 15; f++) begin
        add_bits(1'b0, $urandom_range(0, 5));
        if ($urandom_range(0, 4) == 0) begin
          add_bits(1'b1, $urandom_range(1, H));
          add_bits(1'b0, $urandom_range(1, 3));
        end
        add_frame(8'($urandom), ($urandom_range(0, 3) == 0));
      end
      add_bits(1'b0, 10);
      play($sformatf("rand%0d", seg));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
